ex: RTL
=======

Name: ex

Overview:
- Execute stage of the 5-stage RV32IM core.
- Consumes operands, ALU control, and writeback tag from the ID/EX pipeline register; produces writeback data, address and enable for the EX/MEM register.
- Single-cycle ALU and MUL ops are combinational.
- DIV/DIVU/REM/REMU run on an iterative radix-2 divider that stalls the upstream pipeline while busy.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- DIV_CNT_W, 5, iteration counter width (XLEN = 2^DIV_CNT_W).

Ports:
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_ex_reg_op_a_i  in  32  operand A (rs1 / pc)
- id_ex_reg_op_b_i  in  32  operand B (rs2 / imm)
- id_ex_reg_ALUctrl_i  in  5  ALU control code
- id_ex_reg_reg_waddr_i  in  5  destination register
- id_ex_reg_reg_we_i  in  1  destination write enable
- ex_reg_wdata_o  out  32  result
- ex_reg_waddr_o  out  5  destination register, passthrough
- ex_reg_we_o  out  1  qualified write enable
- ex_stall_o  out  1  hold PC, IF/ID and ID/EX; bubble into EX/MEM

Behaviour:
- Reset: synchronous, active-low. While rst_n=0 at a clock edge:
  - FSM goes to IDLE.
  - Counter, quotient, remainder and divisor regs clear to 0.
  - All outputs read 0 during the reset cycle.
  - A division in progress is abandoned; no result is produced.
- ALUctrl codes:
  - NO_OP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10
  - MUL=11, MULH=12, MULHU=13, MULHSU=14
  - DIV=15, DIVU=16, REM=17, REMU=18
  - Codes 19-31 behave as NO_OP.
- Shift amount is op_b[4:0]. SLT/SLTU produce 0 or 1.
- MUL returns the low 32 bits of the 64-bit product. MULH/MULHU/MULHSU return the high 32 bits with signed×signed, unsigned×unsigned, and signed×unsigned operands respectively.
- NO_OP/unknown codes: wdata_o=0, we_o=0.
- Non-divide ops:
  - Zero latency; outputs are combinational from inputs.
  - we_o = reg_we_i; waddr_o = reg_waddr_i.
  - stall_o=0.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE, divide code present:
    - stall_o=1 combinationally; we_o=0.
    - If divisor==0 or signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): load the special result and go to DONE.
    - Otherwise latch |A| and |B| (raw values for unsigned ops), record the result sign, clear counter, go to BUSY.
  - BUSY:
    - One restoring shift-subtract iteration per cycle; stall_o=1, we_o=0.
    - After iteration with counter==31, go to DONE.
  - DONE:
    - stall_o=0.
    - wdata_o = sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU).
    - we_o = reg_we_i; waddr_o = reg_waddr_i.
    - Next state: IDLE unconditionally.
- Normal divide latency: stall asserted 33 cycles (IDLE cycle + 32 BUSY). Result is presented in the 34th cycle, in DONE.
- Special-case latency: 1 stall cycle; result presented in the 2nd cycle.
- Special results:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=A.
  - Overflow: quotient=0x80000000, remainder=0.
- Signs: quotient is negated when operand signs differ (signed ops only). Remainder takes the sign of the dividend.
- Input stability: ID/EX inputs are held stable by upstream while stall_o=1. Latched operands are used in BUSY regardless.
- Back-to-back divides: after DONE the pipe advances. The next divide seen in IDLE starts a new operation, with no shared state.
- waddr_o is x0: no special handling; the regfile ignores x0.

Optional Feature:
- Macro: EX_DIV_EN.
- Defined: iterative divider and FSM present, as above.
- Undefined: divider logic omitted.
  - Codes 15-18 behave as NO_OP (wdata_o=0, we_o=0).
  - ex_stall_o tied to 0.

Test Plan:
- Reset, then ADD with A=0x7FFFFFFF, B=1, we=1, waddr=5 -> same cycle wdata_o=0x80000000, we_o=1, waddr_o=5, stall_o=0.
- MULH A=0xFFFFFFFE (-2), B=3 -> wdata_o=0xFFFFFFFF. MULHU with the same operands -> 0x00000002. MUL -> 0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 -> stall_o high 33 cycles, then quotient 0xFFFFFFFD with we_o=1 for one cycle. REM with the same operands -> 0xFFFFFFFF.
- DIVU A=100, B=0 -> stall 1 cycle, then wdata_o=0xFFFFFFFF. REMU with the same operands -> 100. DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000 after 1 stall cycle.
- DIVU 1000/7 started; rst_n=0 at BUSY cycle 10 -> outputs 0 and stall_o=0 during reset. After release, DIVU 9/3 -> quotient 3 after 33 stall cycles, with no residue from the aborted op.
- Build without EX_DIV_EN: DIV A=10, B=2 -> stall_o=0, we_o=0, wdata_o=0.

Source files
------------

// File: rtl/ex.sv
// Execute stage of the RV32IM core: combinational ALU/multiplier plus an optional
// iterative radix-2 divider that stalls the pipe while busy (enabled by EX_DIV_EN).
module ex #(
  parameter int XLEN      = 32,
  parameter int DIV_CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] id_ex_reg_op_a_i,
  input  logic [XLEN-1:0] id_ex_reg_op_b_i,
  input  logic [4:0]      id_ex_reg_ALUctrl_i,
  input  logic [4:0]      id_ex_reg_reg_waddr_i,
  input  logic            id_ex_reg_reg_we_i,
  output logic [XLEN-1:0] ex_reg_wdata_o,
  output logic [4:0]      ex_reg_waddr_o,
  output logic            ex_reg_we_o,
  output logic            ex_stall_o
);

  localparam logic [4:0] ALU_ADD    = 5'd1;
  localparam logic [4:0] ALU_SUB    = 5'd2;
  localparam logic [4:0] ALU_AND    = 5'd3;
  localparam logic [4:0] ALU_OR     = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SLL    = 5'd6;
  localparam logic [4:0] ALU_SRL    = 5'd7;
  localparam logic [4:0] ALU_SRA    = 5'd8;
  localparam logic [4:0] ALU_SLT    = 5'd9;
  localparam logic [4:0] ALU_SLTU   = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd11;
  localparam logic [4:0] ALU_MULH   = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_MULHSU = 5'd14;

  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [4:0]        shamt;
  logic              mul_sa;
  logic              mul_sb;
  logic [2*XLEN-1:0] mul_ea;
  logic [2*XLEN-1:0] mul_eb;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   alu_res;
  logic              alu_vld;

  assign op_a  = id_ex_reg_op_a_i;
  assign op_b  = id_ex_reg_op_b_i;
  assign shamt = op_b[4:0];

  // One shared multiplier: extend each operand by its signedness so the low
  // 2*XLEN bits of the product serve MUL, MULH, MULHU and MULHSU alike.
  assign mul_sa   = (id_ex_reg_ALUctrl_i == ALU_MULH) || (id_ex_reg_ALUctrl_i == ALU_MULHSU);
  assign mul_sb   = (id_ex_reg_ALUctrl_i == ALU_MULH);
  assign mul_ea   = {{XLEN{mul_sa & op_a[XLEN-1]}}, op_a};
  assign mul_eb   = {{XLEN{mul_sb & op_b[XLEN-1]}}, op_b};
  assign mul_prod = mul_ea * mul_eb;

  always_comb begin
    alu_res = '0;
    alu_vld = 1'b1;
    case (id_ex_reg_ALUctrl_i)
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_OR:     alu_res = op_a | op_b;
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_SLL:    alu_res = op_a << shamt;
      ALU_SRL:    alu_res = op_a >> shamt;
      ALU_SRA:    alu_res = $signed(op_a) >>> shamt;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_MUL:    alu_res = mul_prod[XLEN-1:0];
      ALU_MULH,
      ALU_MULHU,
      ALU_MULHSU: alu_res = mul_prod[2*XLEN-1:XLEN];
      default:    alu_vld = 1'b0;
    endcase
  end

  assign ex_reg_waddr_o = rst_n ? id_ex_reg_reg_waddr_i : 5'd0;

`ifdef EX_DIV_EN
  localparam logic [4:0] ALU_DIV  = 5'd15;
  localparam logic [4:0] ALU_REM  = 5'd17;
  localparam logic [4:0] ALU_REMU = 5'd18;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t               state_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]      quo_q, rem_q, dvs_q;
  logic                 neg_quo_q, neg_rem_q;
  logic [XLEN-1:0]      quo_d, rem_d;
  logic [XLEN:0]        rem_sh, rem_diff;
  logic                 is_div, is_signed, is_rem, div_zero, div_ovf;
  logic [XLEN-1:0]      min_int, abs_a, abs_b, div_res;

  assign min_int   = {1'b1, {(XLEN-1){1'b0}}};
  assign is_div    = (id_ex_reg_ALUctrl_i >= ALU_DIV) && (id_ex_reg_ALUctrl_i <= ALU_REMU);
  assign is_signed = (id_ex_reg_ALUctrl_i == ALU_DIV) || (id_ex_reg_ALUctrl_i == ALU_REM);
  assign is_rem    = (id_ex_reg_ALUctrl_i == ALU_REM) || (id_ex_reg_ALUctrl_i == ALU_REMU);
  assign div_zero  = (op_b == '0);
  assign div_ovf   = is_signed && (op_a == min_int) && (op_b == '1);
  assign abs_a     = (is_signed && op_a[XLEN-1]) ? -op_a : op_a;
  assign abs_b     = (is_signed && op_b[XLEN-1]) ? -op_b : op_b;

  // Restoring step: the dividend is shifted out of quo_q while quotient bits
  // are shifted in; a clear borrow bit means the trial subtraction sticks.
  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};
  assign rem_d    = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
  assign quo_d    = {quo_q[XLEN-2:0], ~rem_diff[XLEN]};

  assign div_res = is_rem ? (neg_rem_q ? -rem_q : rem_q)
                          : (neg_quo_q ? -quo_q : quo_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_div) begin
            if (div_zero || div_ovf) begin
              quo_q     <= div_zero ? '1 : min_int;
              rem_q     <= div_zero ? op_a : '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= ST_DONE;
            end else begin
              quo_q     <= abs_a;
              rem_q     <= '0;
              dvs_q     <= abs_b;
              neg_quo_q <= is_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
              neg_rem_q <= is_signed & op_a[XLEN-1];
              cnt_q     <= '0;
              state_q   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + DIV_CNT_W'(1);
          if (cnt_q == '1) state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ex_reg_wdata_o = '0;
    ex_reg_we_o    = 1'b0;
    ex_stall_o     = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          ex_stall_o     = is_div;
          ex_reg_wdata_o = alu_res;
          ex_reg_we_o    = alu_vld & id_ex_reg_reg_we_i;
        end
        ST_BUSY: ex_stall_o = 1'b1;
        default: begin
          ex_reg_wdata_o = div_res;
          ex_reg_we_o    = id_ex_reg_reg_we_i;
        end
      endcase
    end
  end
`else
  // Without the divider the stage is purely combinational.
  logic [DIV_CNT_W:0] unused_sig;
  assign unused_sig = {{DIV_CNT_W{1'b0}}, clk};

  assign ex_reg_wdata_o = rst_n ? alu_res : '0;
  assign ex_reg_we_o    = rst_n & alu_vld & id_ex_reg_reg_we_i;
  assign ex_stall_o     = 1'b0;
`endif

endmodule
